// File: rtl/picorv32_arb_pkg.sv
// Shared types and constants for the PicoRV32 two-master memory arbiter.
package picorv32_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Index of a bus master: 0 = CPU core, 1 = DMA/debug master.
  typedef logic owner_t;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/picorv32_arb_watchdog.sv
// Watchdog for a granted transfer: counts busy cycles without a slave
// response and flags the cycle in which the allowance runs out.
// TIMEOUT_CYCLES = 0 keeps expire permanently low.
module picorv32_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] count;

  // Saturating up-counter of stalled busy cycles, cleared while idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  assign expire = (TIMEOUT_CYCLES > 0) && enable && (count == LAST);

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Round-robin arbiter sharing one PicoRV32 native-bus slave between m0
// (CPU core) and m1 (DMA/debug). A grant is held until the slave answers
// or the watchdog forces an error completion.
//
// state | meaning
// IDLE  | no owner; slave request low; arbitrate pending requests
// BUSY  | owner's request passed to slave; wait for ready or timeout
module picorv32_mem_arbiter
  import picorv32_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,

  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,

  output logic        s_mem_valid,
  output logic        s_mem_instr,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,

  output logic        timeout_err,
  output logic        grant_owner
);

  arb_state_t  state_q, state_d;
  owner_t      owner_q, owner_d;
  owner_t      last_q, last_d;
  owner_t      pick;
  logic        wd_expire;
  logic        done;
  logic [31:0] done_rdata;

  picorv32_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state_q == IDLE),
    .enable ((state_q == BUSY) && !s_mem_ready),
    .expire (wd_expire)
  );

  // State, current owner and round-robin history registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Arbitration, owner muxing and completion (slave response beats timeout).
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    s_mem_valid  = 1'b0;
    s_mem_instr  = 1'b0;
    s_mem_addr   = '0;
    s_mem_wdata  = '0;
    s_mem_wstrb  = '0;
    m0_mem_ready = 1'b0;
    m0_mem_rdata = '0;
    m1_mem_ready = 1'b0;
    m1_mem_rdata = '0;
    timeout_err  = 1'b0;
    done         = 1'b0;
    done_rdata   = '0;
    pick         = (m0_mem_valid && m1_mem_valid) ? ~last_q : m1_mem_valid;

    case (state_q)
      IDLE: begin
        if (m0_mem_valid || m1_mem_valid) begin
          state_d = BUSY;
          owner_d = pick;
          last_d  = pick;
        end
      end
      BUSY: begin
        if (owner_q) begin
          s_mem_valid = m1_mem_valid;
          s_mem_instr = m1_mem_instr;
          s_mem_addr  = m1_mem_addr;
          s_mem_wdata = m1_mem_wdata;
          s_mem_wstrb = m1_mem_wstrb;
        end else begin
          s_mem_valid = m0_mem_valid;
          s_mem_instr = m0_mem_instr;
          s_mem_addr  = m0_mem_addr;
          s_mem_wdata = m0_mem_wdata;
          s_mem_wstrb = m0_mem_wstrb;
        end
        if (s_mem_ready) begin
          done       = 1'b1;
          done_rdata = s_mem_rdata;
        end else if (wd_expire) begin
          done        = 1'b1;
          done_rdata  = ERR_RDATA;
          s_mem_valid = 1'b0;
          timeout_err = 1'b1;
        end
        if (done) begin
          state_d = IDLE;
          if (owner_q) begin
            m1_mem_ready = 1'b1;
            m1_mem_rdata = done_rdata;
          end else begin
            m0_mem_ready = 1'b1;
            m0_mem_rdata = done_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_owner = owner_q;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
module tb_picorv32_mem_arbiter;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_mem_valid, m0_mem_instr, m0_mem_ready;
  logic [31:0] m0_mem_addr, m0_mem_wdata, m0_mem_rdata;
  logic [3:0]  m0_mem_wstrb;
  logic        m1_mem_valid, m1_mem_instr, m1_mem_ready;
  logic [31:0] m1_mem_addr, m1_mem_wdata, m1_mem_rdata;
  logic [3:0]  m1_mem_wstrb;
  logic        s_mem_valid, s_mem_instr, s_mem_ready;
  logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [3:0]  s_mem_wstrb;
  logic        timeout_err, grant_owner;

  int checks = 0;
  int errors = 0;

  // Reference model: transaction view of the arbiter.
  int md_busy, md_owner, md_last, md_go, md_age;
  // Expected outputs of the most recent cycle.
  logic        e_r0, e_r1, e_sv, e_si, e_terr, e_go;
  logic [31:0] e_d0, e_d1, e_sa, e_sw;
  logic [3:0]  e_ss;
  // Observed DUT values of the most recent cycle.
  logic        obs_r0, obs_sv, obs_go, obs_terr;
  logic [31:0] obs_d0;
  logic [3:0]  obs_wstrb;

  picorv32_mem_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
    .clk(clk), .resetn(resetn),
    .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr), .m0_mem_addr(m0_mem_addr),
    .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb), .m0_mem_ready(m0_mem_ready),
    .m0_mem_rdata(m0_mem_rdata),
    .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr), .m1_mem_addr(m1_mem_addr),
    .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb), .m1_mem_ready(m1_mem_ready),
    .m1_mem_rdata(m1_mem_rdata),
    .s_mem_valid(s_mem_valid), .s_mem_instr(s_mem_instr), .s_mem_addr(s_mem_addr),
    .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb), .s_mem_ready(s_mem_ready),
    .s_mem_rdata(s_mem_rdata),
    .timeout_err(timeout_err), .grant_owner(grant_owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_req(input int m);
    if (m == 0) begin
      m0_mem_valid = 1'b1;
      m0_mem_instr = 1'($urandom_range(0, 1));
      m0_mem_addr  = $urandom;
      m0_mem_wdata = $urandom;
      m0_mem_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    end else begin
      m1_mem_valid = 1'b1;
      m1_mem_instr = 1'($urandom_range(0, 1));
      m1_mem_addr  = $urandom;
      m1_mem_wdata = $urandom;
      m1_mem_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    end
  endtask

  // One clock cycle: predict and compare at negedge, advance model after posedge.
  task automatic step();
    int nb, no, nl, ng, na;
    logic ov, done;
    logic [31:0] drd;
    @(negedge clk);
    if (!resetn) begin
      md_busy = 0; md_owner = 0; md_last = 1; md_go = 0; md_age = 0;
    end
    nb = md_busy; no = md_owner; nl = md_last; ng = md_go; na = md_age;
    e_r0 = 0; e_r1 = 0; e_d0 = 0; e_d1 = 0; e_sv = 0; e_si = 0;
    e_sa = 0; e_sw = 0; e_ss = 0; e_terr = 0;
    e_go = (md_go != 0);
    done = 0; drd = 0;
    if (resetn && md_busy != 0) begin
      ov   = (md_owner != 0) ? m1_mem_valid : m0_mem_valid;
      e_si = (md_owner != 0) ? m1_mem_instr : m0_mem_instr;
      e_sa = (md_owner != 0) ? m1_mem_addr  : m0_mem_addr;
      e_sw = (md_owner != 0) ? m1_mem_wdata : m0_mem_wdata;
      e_ss = (md_owner != 0) ? m1_mem_wstrb : m0_mem_wstrb;
      if (s_mem_ready) begin
        done = 1; drd = s_mem_rdata; e_sv = ov;
      end else if (md_age == TO - 1) begin
        done = 1; drd = ERR; e_terr = 1; e_sv = 0;
      end else begin
        e_sv = ov; na = md_age + 1;
      end
      if (done) begin
        nb = 0;
        if (md_owner != 0) begin e_r1 = 1; e_d1 = drd; end
        else begin e_r0 = 1; e_d0 = drd; end
      end
    end else if (resetn && (m0_mem_valid || m1_mem_valid)) begin
      no = (m0_mem_valid && m1_mem_valid) ? 1 - md_last : (m1_mem_valid ? 1 : 0);
      nb = 1; na = 0; nl = no; ng = no;
    end
    chk("m0_ready", m0_mem_ready, e_r0);
    chk("m0_rdata", m0_mem_rdata, e_d0);
    chk("m1_ready", m1_mem_ready, e_r1);
    chk("m1_rdata", m1_mem_rdata, e_d1);
    chk("s_valid",  s_mem_valid,  e_sv);
    chk("s_instr",  s_mem_instr,  e_si);
    chk("s_addr",   s_mem_addr,   e_sa);
    chk("s_wdata",  s_mem_wdata,  e_sw);
    chk("s_wstrb",  s_mem_wstrb,  e_ss);
    chk("timeout_err", timeout_err, e_terr);
    chk("grant_owner", grant_owner, e_go);
    obs_r0 = m0_mem_ready; obs_d0 = m0_mem_rdata; obs_sv = s_mem_valid;
    obs_go = grant_owner; obs_terr = timeout_err; obs_wstrb = s_mem_wstrb;
    @(posedge clk);
    #1;
    if (resetn) begin
      md_busy = nb; md_owner = no; md_last = nl; md_go = ng; md_age = na;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic q[$];
    int   tcnt;
    bit   stall;
    md_busy = 0; md_owner = 0; md_last = 1; md_go = 0; md_age = 0;
    resetn = 1'b0;
    m0_mem_valid = 0; m0_mem_instr = 0; m0_mem_addr = 0; m0_mem_wdata = 0; m0_mem_wstrb = 0;
    m1_mem_valid = 0; m1_mem_instr = 0; m1_mem_addr = 0; m1_mem_wdata = 0; m1_mem_wstrb = 0;
    s_mem_ready = 0; s_mem_rdata = 0;
    step(); step();
    resetn = 1'b1;
    step();

    // Single m0 read, slave answers on the third busy cycle.
    m0_mem_valid = 1; m0_mem_addr = 32'h0000_0100; m0_mem_wstrb = 0;
    step();
    chk("t1_svalid_after_1", obs_sv, 1'b0);
    step();
    chk("t1_svalid_busy", obs_sv, 1'b1);
    step();
    s_mem_ready = 1; s_mem_rdata = 32'h1234_5678;
    step();
    chk("t1_ready", obs_r0, 1'b1);
    chk("t1_rdata", obs_d0, 32'h1234_5678);
    m0_mem_valid = 0; s_mem_ready = 0;
    step();

    // Both masters requesting continuously right after reset.
    resetn = 0; step(); resetn = 1;
    m0_mem_valid = 1; m1_mem_valid = 1; m1_mem_addr = 32'h40; s_mem_ready = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (obs_sv) q.push_back(obs_go);
    end
    chk("t2_grant_count", q.size(), 4);
    for (int i = 0; i < q.size() && i < 4; i++) chk("t2_grant_order", q[i], (i % 2));
    m0_mem_valid = 0; m1_mem_valid = 0; s_mem_ready = 0;
    step();

    // m1 write arrives while m0 is mid-transfer.
    m0_mem_valid = 1; m0_mem_wstrb = 0;
    step();
    m1_mem_valid = 1; m1_mem_addr = 32'h10; m1_mem_wstrb = 4'b0011; m1_mem_wdata = 32'hA5A5_0F0F;
    step();
    chk("t3_m0_wstrb", obs_wstrb, 4'b0000);
    step();
    s_mem_ready = 1;
    step();
    m0_mem_valid = 0; s_mem_ready = 0;
    step();
    step();
    chk("t3_m1_owner", obs_go, 1'b1);
    chk("t3_m1_wstrb", obs_wstrb, 4'b0011);
    s_mem_ready = 1;
    step();
    m1_mem_valid = 0; s_mem_ready = 0;
    step();

    // Slave never answers: watchdog completes the transfer.
    tcnt = 0;
    m0_mem_valid = 1;
    step();
    for (int i = 0; i < TO; i++) begin
      step();
      tcnt += int'(obs_terr);
    end
    chk("t4_err_ready", obs_r0, 1'b1);
    chk("t4_err_rdata", obs_d0, ERR);
    m0_mem_valid = 0; s_mem_ready = 1;
    step();
    tcnt += int'(obs_terr);
    chk("t4_late_ready_ignored", obs_r0, 1'b0);
    chk("t4_terr_pulses", tcnt, 1);
    s_mem_ready = 0;

    // Slave answers in the expiry cycle: slave data wins.
    m0_mem_valid = 1;
    step();
    for (int i = 0; i < TO - 1; i++) step();
    s_mem_ready = 1; s_mem_rdata = 32'hCAFE_F00D;
    step();
    chk("t5_ready", obs_r0, 1'b1);
    chk("t5_rdata", obs_d0, 32'hCAFE_F00D);
    chk("t5_no_terr", obs_terr, 1'b0);
    m0_mem_valid = 0; s_mem_ready = 0;
    step();

    // Reset during BUSY, then a tie goes to m0.
    m1_mem_valid = 1;
    step(); step();
    resetn = 0; m0_mem_valid = 1;
    step();
    chk("t6_reset_svalid", obs_sv, 1'b0);
    chk("t6_reset_grant", obs_go, 1'b0);
    resetn = 1;
    step(); step();
    chk("t6_tie_owner", obs_go, 1'b0);
    s_mem_ready = 1;
    step();
    m0_mem_valid = 0; m1_mem_valid = 0; s_mem_ready = 0;
    step();

    // Randomized traffic with occasional stalls and resets.
    stall = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 100 == 0) stall = ($urandom_range(0, 3) == 0);
      if (!resetn) resetn = 1;
      else if ($urandom_range(0, 299) == 0) resetn = 0;
      if (m0_mem_valid && e_r0) begin
        if ($urandom_range(0, 1) == 0) new_req(0); else m0_mem_valid = 0;
      end else if (m0_mem_valid) begin
        if ($urandom_range(0, 63) == 0) m0_mem_valid = 0;
      end else if ($urandom_range(0, 2) == 0) new_req(0);
      if (m1_mem_valid && e_r1) begin
        if ($urandom_range(0, 1) == 0) new_req(1); else m1_mem_valid = 0;
      end else if (m1_mem_valid) begin
        if ($urandom_range(0, 63) == 0) m1_mem_valid = 0;
      end else if ($urandom_range(0, 2) == 0) new_req(1);
      s_mem_ready = stall ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
      s_mem_rdata = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_arbiter.md
# picorv32_mem_arbiter

- Two-master, one-slave arbiter for the PicoRV32 native memory bus (valid/ready, addr/wdata/wstrb/rdata).
- Shares a single memory slave between m0 (CPU core) and m1 (DMA/debug master).
- Grants are round-robin and locked until the slave completes the transfer.
- A watchdog terminates transfers the slave never completes.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024, granted cycles without s_mem_ready before forced completion; 0 disables the watchdog
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned to the owner on timeout

Ports. Per-master signals exist for both masters as m0_* and m1_*, written below as mX_*.
- clk  in  1  single clock; all state on posedge
- resetn  in  1  asynchronous, active-low reset
- mX_mem_valid  in  1  master request, held until mX_mem_ready
- mX_mem_instr  in  1  instruction-fetch qualifier
- mX_mem_addr  in  32  byte address
- mX_mem_wdata  in  32  write data
- mX_mem_wstrb  in  4  byte strobes; 0 = read
- mX_mem_ready  out  1  completion pulse to master
- mX_mem_rdata  out  32  read data, valid with mX_mem_ready
- s_mem_valid  out  1  request to slave
- s_mem_instr  out  1  owner's instr qualifier
- s_mem_addr, s_mem_wdata, s_mem_wstrb  out  32/32/4  owner's request fields
- s_mem_ready  in  1  slave completion
- s_mem_rdata  in  32  slave read data
- timeout_err  out  1  one-cycle pulse on watchdog expiry
- grant_owner  out  1  current/last owner index, registered

## Operation
- State machine, registered: IDLE, BUSY.
- IDLE:
  - s_mem_valid = 0.
  - If any mX_mem_valid is high: set owner, go to BUSY.
  - Both requesting: grant the master not granted last (round-robin).
  - After reset, the last-granted register = 1, so m0 wins the first tie.
- BUSY:
  - Slave request outputs = owner's inputs, passed through combinationally.
  - s_mem_valid = owner's mem_valid.
  - Non-owner: mem_ready = 0, mem_rdata = 0; its request stays pending.
- Completion:
  - In BUSY with s_mem_ready = 1: owner's mem_ready = 1 and mem_rdata = s_mem_rdata in the same cycle.
  - Next state is IDLE.
- Watchdog:
  - Counter clears on IDLE→BUSY and increments each BUSY cycle without s_mem_ready.
  - At count == TIMEOUT_CYCLES-1 with no s_mem_ready: owner's mem_ready = 1, mem_rdata = ERR_RDATA, s_mem_valid forced 0, timeout_err = 1 for that cycle.
  - Next state is IDLE.
- s_mem_ready while in IDLE (late response) is ignored; no master sees it.
- s_mem_ready and watchdog expiry in the same cycle: the slave response wins; no timeout_err.
- Owner drops mem_valid before ready (protocol violation): s_mem_valid follows it low; the arbiter stays BUSY until ready or timeout.
- Reset, including mid-transfer:
  - State = IDLE, counter = 0, last-grant = 1, grant_owner = 0.
  - All outputs 0 while resetn is low.
  - An in-flight transfer is abandoned.

## Timing
- Arbitration latency: 1 cycle from mX_mem_valid high (state IDLE) to s_mem_valid high.
- Completion: ready/rdata to the owner are combinational from s_mem_ready/s_mem_rdata; zero added latency.
- One mandatory IDLE bubble after each completion, so a re-request by the same master costs 1 cycle.
- A master seeing ready may start a new request the next cycle; it is arbitrated in that IDLE cycle.
- Minimum transfer occupancy: 2 cycles (IDLE + BUSY with immediate ready).
- Counter width: $clog2(TIMEOUT_CYCLES+1), saturating; unused when TIMEOUT_CYCLES = 0.

## Structure
- Package picorv32_arb_pkg:
  - arb_state_t enum {IDLE, BUSY}.
  - Owner index typedef.
  - Default ERR_RDATA constant.
- Sub-module picorv32_arb_watchdog: clear/enable inputs, expire output, parameterised by TIMEOUT_CYCLES.
- Muxing and FSM stay in the top module.

## Test plan
- Single m0 read 0x0000_0100, slave ready after 3 cycles with 0x1234_5678 -> s_mem_valid one cycle after m0_mem_valid; m0_mem_ready with rdata 0x1234_5678; m1 outputs stay 0.
- m0 and m1 request simultaneously after reset, both continuously for 4 transfers -> grants m0, m1, m0, m1; each granted transfer shows the IDLE bubble.
- m1 write 0x10 wstrb 4'b0011 while m0 mid-transfer -> m1 held until m0 completes; s_mem_wstrb = 4'b0011 only during m1's BUSY.
- TIMEOUT_CYCLES=8, slave never ready -> at the 8th BUSY cycle: owner ready, rdata 0xDEAD_BEEF, timeout_err pulses once; a later s_mem_ready is ignored.
- s_mem_ready coincident with the expiry cycle -> slave data is returned, timeout_err stays 0.
- resetn low during BUSY -> all outputs 0 immediately; after release, m0 wins the first tie.
